// File: rtl/sync_meas_if.sv
// Sync inputs from the TVP7002 input stage and the timing figures measured from them.
interface sync_meas_if;
   logic        HSYNC_in;
   logic        VSYNC_in;
   logic        FID_in;
   logic        hs_pol;
   logic        vs_pol;
   logic [11:0] h_total;
   logic [7:0]  h_synclen;
   logic [10:0] v_total;
   logic        interlaced;
   logic        h_unstable;
   logic        v_unstable;
   logic        field_pulse;

   modport master (
      output HSYNC_in, VSYNC_in, FID_in, hs_pol, vs_pol,
      input  h_total, h_synclen, v_total, interlaced, h_unstable, v_unstable, field_pulse
   );

   modport slave (
      input  HSYNC_in, VSYNC_in, FID_in, hs_pol, vs_pol,
      output h_total, h_synclen, v_total, interlaced, h_unstable, v_unstable, field_pulse
   );
endinterface

// File: rtl/sync_meas.sv
// Measures line period, hsync width, field length and interlace from latched syncs.
// h_total is published only after STABLE_LINES consecutive matching line periods.
module sync_meas #(
   parameter int H_TOL        = 2,
   parameter int STABLE_LINES = 4
) (
   input logic         PCLK_in,
   input logic         reset_n,
   sync_meas_if.slave  bus
);
   localparam int MW = $clog2(STABLE_LINES + 1);

   logic          hs_q, hs_prev, vs_q, vs_prev;
   logic          h_lead, h_trail, v_lead;
   logic [11:0]   hcnt, candidate;
   logic [MW-1:0] match_cnt, match_next;
   logic [7:0]    hslen;
   logic [10:0]   vcnt, v_diff;
   logic [12:0]   period, h_diff;
   logic          h_match, v_near;
   logic          v_valid, fid_prev, fid_diff, fid_diff_last;

   assign h_lead   = hs_q & ~hs_prev;
   assign h_trail  = ~hs_q & hs_prev;
   assign v_lead   = vs_q & ~vs_prev;
   assign fid_diff = bus.FID_in ^ fid_prev;

   always_comb begin
      period     = {1'b0, hcnt} + 13'd1;
      h_diff     = (period >= {1'b0, candidate}) ? period - {1'b0, candidate}
                                                 : {1'b0, candidate} - period;
      h_match    = (h_diff <= 13'(H_TOL));
      match_next = (match_cnt == MW'(STABLE_LINES)) ? match_cnt : match_cnt + MW'(1);
      v_diff     = (vcnt >= bus.v_total) ? vcnt - bus.v_total : bus.v_total - vcnt;
      v_near     = (v_diff <= 11'd1);
   end

   // Syncs normalised to active-high, then one register stage feeding edge detect.
   always_ff @(posedge PCLK_in or negedge reset_n) begin
      if (!reset_n) begin
         hs_q    <= 1'b0;
         hs_prev <= 1'b0;
         vs_q    <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         // NOTE: non-blocking, so hs_prev takes the old hs_q and the edge pair stays one cycle apart.
         hs_q    <= bus.HSYNC_in ^ ~bus.hs_pol;
         hs_prev <= hs_q;
         vs_q    <= bus.VSYNC_in ^ ~bus.vs_pol;
         vs_prev <= vs_q;
      end
   end

   always_ff @(posedge PCLK_in or negedge reset_n) begin
      if (!reset_n) begin
         hcnt           <= '0;
         candidate      <= '0;
         match_cnt      <= '0;
         hslen          <= '0;
         bus.h_total    <= '0;
         bus.h_synclen  <= '0;
         bus.h_unstable <= 1'b1;
      end else begin
         if (h_lead)
            hcnt <= '0;
         else if (hcnt != '1)
            hcnt <= hcnt + 12'd1;

         // A saturated counter means hsync was lost; the edge that ends it is not a valid period.
         if (hcnt == '1) begin
            bus.h_unstable <= 1'b1;
            bus.h_total    <= '0;
            match_cnt      <= '0;
         end else if (h_lead) begin
            if (h_match) begin
               match_cnt <= match_next;
               if (match_next == MW'(STABLE_LINES)) begin
                  bus.h_total    <= candidate;
                  bus.h_unstable <= 1'b0;
               end
            end else begin
               candidate      <= hcnt + 12'd1;
               match_cnt      <= '0;
               bus.h_unstable <= 1'b1;
            end
         end

         if (h_lead)
            hslen <= 8'd1;
         else if (hs_q && hslen != 8'hFF)
            hslen <= hslen + 8'd1;
         if (h_trail)
            bus.h_synclen <= hslen;
      end
   end

   always_ff @(posedge PCLK_in or negedge reset_n) begin
      if (!reset_n) begin
         vcnt            <= '0;
         v_valid         <= 1'b0;
         fid_prev        <= 1'b0;
         fid_diff_last   <= 1'b0;
         bus.v_total     <= '0;
         bus.v_unstable  <= 1'b1;
         bus.interlaced  <= 1'b0;
         bus.field_pulse <= 1'b0;
      end else begin
         bus.field_pulse <= v_lead;
         // V edge wins over a coincident H edge: that line belongs to the new field, which starts at 0.
         if (v_lead) begin
            bus.v_total    <= vcnt;
            vcnt           <= '0;
            bus.v_unstable <= !(v_valid && v_near);
            v_valid        <= 1'b1;
            fid_prev       <= bus.FID_in;
            fid_diff_last  <= fid_diff;
            if (!fid_diff)
               bus.interlaced <= 1'b0;
            else if (fid_diff_last)
               bus.interlaced <= 1'b1;
         end else if (vcnt == '1) begin
            bus.v_unstable <= 1'b1;
            bus.v_total    <= '0;
            bus.interlaced <= 1'b0;
            v_valid        <= 1'b0;
            fid_diff_last  <= 1'b0;
         end else if (h_lead) begin
            vcnt <= vcnt + 11'd1;
         end
      end
   end
endmodule

// File: doc/sync_meas.md
SYNC_MEAS -- requirements
Module: sync_meas

Interface
REQ-001 Parameter H_TOL, default 2: maximum pixel-clock difference between line periods that still counts as a match.
REQ-002 Parameter STABLE_LINES, default 4: number of consecutive matching line periods before h_total is published.
REQ-003 PCLK_in  in  1  TVP7002 pixel clock; all logic is clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 HSYNC_in  in  1  latched hsync from the input stage.
REQ-006 VSYNC_in  in  1  latched vsync from the input stage.
REQ-007 FID_in  in  1  latched field ID.
REQ-008 hs_pol  in  1  hsync polarity; 1 = active-high, 0 = active-low.
REQ-009 vs_pol  in  1  vsync polarity; 1 = active-high, 0 = active-low.
REQ-010 h_total  out  12  measured pixel clocks per line.
REQ-011 h_synclen  out  8  measured hsync active width in pixel clocks.
REQ-012 v_total  out  11  measured lines in the last field.
REQ-013 interlaced  out  1  interlaced source detected.
REQ-014 h_unstable  out  1  line period not yet stable.
REQ-015 v_unstable  out  1  field length not stable.
REQ-016 field_pulse  out  1  one-cycle strobe per vsync leading edge.

Function
REQ-017 Sync inputs SHALL be normalised (XOR with inverted polarity) and registered once; a leading edge is a normalised-active sample following an inactive previous sample, and a trailing edge is the reverse.
REQ-018 hcnt (12 bit) SHALL increment every cycle, load 0 on an H leading edge, and saturate at 4095.
REQ-019 On an H leading edge, period = hcnt+1 SHALL be evaluated against the candidate register: |period-candidate| <= H_TOL increments match_cnt (saturating at STABLE_LINES); otherwise candidate <= period, match_cnt <= 0 and h_unstable <= 1.
REQ-020 When match_cnt reaches STABLE_LINES, h_total SHALL be loaded with the candidate and h_unstable cleared on the same edge; latency is 1 cycle after the leading-edge detect.
REQ-021 On hcnt saturation (no hsync for 4096 cycles), the block SHALL set h_unstable=1, h_total=0 and match_cnt=0; the next edge restarts acquisition with period discarded.
REQ-022 hslen (8 bit) SHALL count active cycles, saturate at 255, and be loaded into h_synclen on each H trailing edge.
REQ-023 vcnt (11 bit) SHALL increment on each H leading edge and saturate at 2047.
REQ-024 On a V leading edge: v_total <= vcnt, vcnt <= 0, field_pulse = 1 for exactly one cycle, and FID_in is sampled into fid_prev.
REQ-025 v_unstable SHALL be cleared when the new vcnt is within 1 of the previous v_total, and set otherwise; the first field after reset leaves v_unstable at 1.
REQ-026 On vcnt saturation, the block SHALL set v_unstable=1, v_total=0, interlaced=0, and hold vcnt at 2047 until a V leading edge.
REQ-027 interlaced SHALL be set when the sampled FID differs from fid_prev on 2 consecutive V edges, and cleared on the first V edge where FID equals fid_prev.
REQ-028 When H and V leading edges occur in the same cycle, vcnt SHALL be captured before the H increment, and the new field starts at vcnt=0.
REQ-029 hs_pol and vs_pol are quasi-static; a change mid-stream MAY produce one spurious edge, which the stability logic absorbs.

Reset
REQ-030 While reset_n=0, the following SHALL hold: h_total=0, h_synclen=0, v_total=0, interlaced=0, h_unstable=1, v_unstable=1, field_pulse=0, all counters 0, edge registers at the inactive level.
REQ-031 Reset assertion mid-line or mid-field SHALL discard all partial measurements; after release, acquisition restarts from REQ-017.

Verification
REQ-032 480p: hs_pol=0, HS low 62 of every 858 clocks, 525 lines -> h_unstable clears after the 4th matching line; h_total=858, h_synclen=62, v_total=525 (second field onward), v_unstable=0, interlaced=0.
REQ-033 Jitter: periods alternating 858/859/857 -> h_unstable stays 0 and h_total=858; a single 870 period -> h_unstable=1 until 4 further matches.
REQ-034 480i: FID toggling, fields of 262/263 lines -> v_unstable=0, interlaced=1 from the 2nd toggle; FID stuck -> interlaced=0 on the next V edge.
REQ-035 Sync loss: hsync removed -> 4096 cycles later h_total=0, h_unstable=1; vsync removed -> after 2047 lines v_total=0, v_unstable=1.
REQ-036 Coincident H and V edges plus reset_n pulsed mid-field -> v_total excludes the coincident line; all outputs return to REQ-030 values asynchronously.
